// File: rtl/spi_sram_responder.sv
// SPI-side responder for a 23K640-class serial SRAM (mode 0, MSB first).
// The SPI pins are oversampled on i_clk. The responder decodes READ, WRITE,
// RDSR and WRSR, holds a 2^AW byte array and shifts data back on o_so.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | chip deselected, or just selected and about to start a command
// S_CMD    | shifting in the 8-bit command
// S_ADDR   | shifting in the 16-bit address; only the low AW bits are kept
// S_RDATA  | driving array bytes on each sck fall
// S_WDATA  | shifting in data bytes and writing them to the array
// S_RDSR   | driving the status register repeatedly
// S_WRSR   | shifting in the new status value
// S_IGNORE | transaction finished or illegal; wait for cs high
module spi_sram_responder #(
    parameter int AW = 13
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_sck,
    input  logic          i_cs,
    input  logic          i_si,
    output logic          o_so,
    output logic          o_so_en,
    input  logic [AW-1:0] i_dbg_addr,
    output logic [7:0]    o_dbg_rdata
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_RDATA, S_WDATA, S_RDSR, S_WRSR, S_IGNORE
    } state_t;

    state_t          r_state;
    logic            r_sck_s1, r_sck_s2, r_sck_s3;
    logic            r_cs_s1, r_cs_s2;
    logic            r_si_s1, r_si_s2;
    logic            r_armed;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic [AW-1:0]   r_addr;
    logic            r_addr_hi;
    logic            r_is_read;
    logic            r_one_done;
    logic [7:0]      r_status;
    logic            r_so;
    logic            r_so_en;
    logic            r_wr_pend;
    logic [AW-1:0]   r_wr_addr;
    logic [7:0]      r_wr_data;
    logic [7:0]      r_mem [0:(2**AW)-1];

    logic            w_sck_rise;
    logic            w_sck_fall;
    logic [7:0]      w_shift_in;
    logic [7:0]      w_rd_byte;
    logic            w_seq;
    logic            w_page;
    logic            w_byte_mode;
    logic [AW-1:0]   w_next_addr;

    assign w_sck_rise  = r_sck_s2 & ~r_sck_s3;
    assign w_sck_fall  = ~r_sck_s2 & r_sck_s3;
    assign w_shift_in  = {r_shift[6:0], r_si_s2};
    assign w_rd_byte   = r_mem[r_addr];
    assign w_seq       = (r_status[7:6] == 2'b01);
    assign w_page      = (r_status[7:6] == 2'b10);
    assign w_byte_mode = ~(w_seq | w_page);

    assign o_so        = r_so;
    assign o_so_en     = r_so_en;
    assign o_dbg_rdata = r_mem[i_dbg_addr];

    // Address advance after each completed data byte; page mode wraps in 32 bytes.
    always_comb begin
        w_next_addr = r_addr;
        if (w_seq) begin
            w_next_addr = r_addr + AW'(1);
        end else if (w_page) begin
            w_next_addr[4:0] = r_addr[4:0] + 5'd1;
        end
    end

    // Pin synchronisers and the transaction FSM. The cs synchroniser resets to
    // "selected" so a cs held low through reset release never looks like a new
    // select; r_armed only sets once cs has really been seen high.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_sck_s1   <= 1'b0;
            r_sck_s2   <= 1'b0;
            r_sck_s3   <= 1'b0;
            r_cs_s1    <= 1'b0;
            r_cs_s2    <= 1'b0;
            r_si_s1    <= 1'b0;
            r_si_s2    <= 1'b0;
            r_armed    <= 1'b0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
            r_addr     <= '0;
            r_addr_hi  <= 1'b0;
            r_is_read  <= 1'b0;
            r_one_done <= 1'b0;
            r_status   <= 8'h00;
            r_so       <= 1'b0;
            r_so_en    <= 1'b0;
            r_wr_pend  <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= 8'h00;
        end else begin
            r_sck_s1  <= i_sck;
            r_sck_s2  <= r_sck_s1;
            r_sck_s3  <= r_sck_s2;
            r_cs_s1   <= i_cs;
            r_cs_s2   <= r_cs_s1;
            r_si_s1   <= i_si;
            r_si_s2   <= r_si_s1;
            r_wr_pend <= 1'b0;
            if (r_cs_s2) begin
                r_state   <= S_IDLE;
                r_armed   <= 1'b1;
                r_bit_cnt <= 3'd0;
                r_so      <= 1'b0;
                r_so_en   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_bit_cnt  <= 3'd0;
                        r_addr_hi  <= 1'b0;
                        r_one_done <= 1'b0;
                        r_state    <= r_armed ? S_CMD : S_IGNORE;
                    end
                    S_CMD: if (w_sck_rise) begin
                        r_shift   <= w_shift_in;
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            case (w_shift_in)
                                8'h03: begin r_state <= S_ADDR; r_is_read <= 1'b1; end
                                8'h02: begin r_state <= S_ADDR; r_is_read <= 1'b0; end
                                8'h05: begin r_state <= S_RDSR; r_so_en <= 1'b1; end
                                8'h01: r_state <= S_WRSR;
                                default: r_state <= S_IGNORE;
                            endcase
                        end
                    end
                    S_ADDR: if (w_sck_rise) begin
                        r_addr    <= {r_addr[AW-2:0], r_si_s2};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            if (r_addr_hi) begin
                                r_state <= r_is_read ? S_RDATA : S_WDATA;
                                r_so_en <= r_is_read;
                            end else begin
                                r_addr_hi <= 1'b1;
                            end
                        end
                    end
                    S_RDATA: if (w_sck_fall) begin
                        // In byte mode the last bit is held until the following fall.
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_one_done) begin
                            r_state <= S_IGNORE;
                            r_so    <= 1'b0;
                            r_so_en <= 1'b0;
                        end else begin
                            if (r_bit_cnt == 3'd0) begin
                                r_so    <= w_rd_byte[7];
                                r_shift <= {w_rd_byte[6:0], 1'b0};
                            end else begin
                                r_so    <= r_shift[7];
                                r_shift <= {r_shift[6:0], 1'b0};
                            end
                            if (r_bit_cnt == 3'd7) begin
                                r_addr     <= w_next_addr;
                                r_one_done <= w_byte_mode;
                            end
                        end
                    end
                    S_WDATA: if (w_sck_rise) begin
                        r_shift   <= w_shift_in;
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_wr_pend <= 1'b1;
                            r_wr_addr <= r_addr;
                            r_wr_data <= w_shift_in;
                            r_addr    <= w_next_addr;
                            if (w_byte_mode) r_state <= S_IGNORE;
                        end
                    end
                    S_RDSR: if (w_sck_fall) begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd0) begin
                            r_so    <= r_status[7];
                            r_shift <= {r_status[6:0], 1'b0};
                        end else begin
                            r_so    <= r_shift[7];
                            r_shift <= {r_shift[6:0], 1'b0};
                        end
                    end
                    S_WRSR: if (w_sck_rise) begin
                        r_shift   <= w_shift_in;
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_status <= {w_shift_in[7:6], 5'b00000, w_shift_in[0]};
                            r_state  <= S_IGNORE;
                        end
                    end
                    S_IGNORE: begin
                        r_so    <= 1'b0;
                        r_so_en <= 1'b0;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Array write one cycle after the final data bit; the array is never reset.
    always_ff @(posedge i_clk) begin
        if (r_wr_pend) r_mem[r_wr_addr] <= r_wr_data;
    end

endmodule

// File: tb/tb_spi_sram_responder.sv
// Directed bench for spi_sram_responder: acts as an SPI mode-0 master with
// 8-clock sck phases and checks status, array and serial read-back values.
module tb_spi_sram_responder;

    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          rst;
    logic          sck;
    logic          cs;
    logic          si;
    logic          so;
    logic          so_en;
    logic [AW-1:0] dbg_addr;
    logic [7:0]    dbg_rdata;

    int checks   = 0;
    int failures = 0;
    bit en_seen  = 1'b0;

    spi_sram_responder #(.AW(AW)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_sck       (sck),
        .i_cs        (cs),
        .i_si        (si),
        .o_so        (so),
        .o_so_en     (so_en),
        .i_dbg_addr  (dbg_addr),
        .o_dbg_rdata (dbg_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (so_en === 1'b1) en_seen = 1'b1;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            si = tx[i];
            clks(8);
            rx[i] = so;
            sck = 1'b1;
            clks(8);
            sck = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        spi_bits(tx, 8, rx);
    endtask

    task automatic cs_start();
        cs = 1'b0;
        clks(8);
    endtask

    task automatic cs_end();
        clks(8);
        cs = 1'b1;
        clks(8);
    endtask

    task automatic wrsr(input logic [7:0] v);
        logic [7:0] rx;
        cs_start();
        spi_byte(8'h01, rx);
        spi_byte(v, rx);
        cs_end();
    endtask

    task automatic rdsr(output logic [7:0] v);
        logic [7:0] rx;
        cs_start();
        spi_byte(8'h05, rx);
        spi_byte(8'h00, v);
        cs_end();
    endtask

    task automatic mem_write(input logic [15:0] a, input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2, input int n);
        logic [7:0] rx;
        cs_start();
        spi_byte(8'h02, rx);
        spi_byte(a[15:8], rx);
        spi_byte(a[7:0], rx);
        spi_byte(d0, rx);
        if (n > 1) spi_byte(d1, rx);
        if (n > 2) spi_byte(d2, rx);
        cs_end();
    endtask

    task automatic mem_read(input logic [15:0] a, input int n, output logic [7:0] q0,
                            output logic [7:0] q1, output logic [7:0] q2);
        logic [7:0] rx;
        q1 = 8'h00;
        q2 = 8'h00;
        cs_start();
        spi_byte(8'h03, rx);
        spi_byte(a[15:8], rx);
        spi_byte(a[7:0], rx);
        spi_byte(8'h00, q0);
        if (n > 1) spi_byte(8'h00, q1);
        if (n > 2) spi_byte(8'h00, q2);
        cs_end();
    endtask

    task automatic peek(input logic [AW-1:0] a, input string tag, input logic [7:0] exp);
        dbg_addr = a;
        #1;
        check(tag, dbg_rdata, exp);
    endtask

    initial begin
        logic [7:0] v, q0, q1, q2, rx;
        logic [7:0] acc;
        rst = 1'b1; cs = 1'b1; sck = 1'b0; si = 1'b0; dbg_addr = '0;
        clks(4);
        check("reset_so", so, 1'b0);
        check("reset_so_en", so_en, 1'b0);
        rst = 1'b0;
        clks(4);

        rdsr(v);
        check("status_after_reset", v, 8'h00);

        // WRSR 0x41 then RDSR twice in one transaction
        wrsr(8'h41);
        cs_start();
        check("so_en_before_cmd", so_en, 1'b0);
        spi_byte(8'h05, rx);
        check("so_en_rdsr", so_en, 1'b1);
        spi_byte(8'h00, v);
        check("rdsr_first", v, 8'h41);
        spi_byte(8'h00, v);
        check("rdsr_repeat", v, 8'h41);
        cs_end();
        check("so_en_after_cs", so_en, 1'b0);

        // Byte mode
        wrsr(8'h00);
        mem_write(16'h0124, 8'h3C, 8'h00, 8'h00, 1);
        mem_write(16'h0123, 8'hA5, 8'h77, 8'h00, 2);
        peek(13'h0123, "byte_wr_0123", 8'hA5);
        peek(13'h0124, "byte_wr_0124_untouched", 8'h3C);
        mem_read(16'h0123, 2, q0, q1, q2);
        check("byte_rd_first", q0, 8'hA5);
        check("byte_rd_second_zero", q1, 8'h00);

        // Sequential mode with address wrap
        wrsr(8'h40);
        mem_write(16'h1FFF, 8'h11, 8'h22, 8'h33, 3);
        peek(13'h1FFF, "seq_wr_1fff", 8'h11);
        peek(13'h0000, "seq_wr_0000", 8'h22);
        peek(13'h0001, "seq_wr_0001", 8'h33);
        mem_read(16'h1FFF, 3, q0, q1, q2);
        check("seq_rd_0", q0, 8'h11);
        check("seq_rd_1", q1, 8'h22);
        check("seq_rd_2", q2, 8'h33);

        // Page mode with 32-byte wrap
        wrsr(8'h80);
        mem_write(16'h003E, 8'hAA, 8'hBB, 8'hCC, 3);
        peek(13'h003E, "page_wr_003e", 8'hAA);
        peek(13'h003F, "page_wr_003f", 8'hBB);
        peek(13'h0020, "page_wr_0020", 8'hCC);

        // Partial write byte is discarded
        wrsr(8'h00);
        mem_write(16'h0010, 8'h5A, 8'h00, 8'h00, 1);
        peek(13'h0010, "prefill_0010", 8'h5A);
        cs_start();
        spi_byte(8'h02, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h10, rx);
        spi_bits(8'hC3, 5, rx);
        cs_end();
        peek(13'h0010, "partial_wr_discarded", 8'h5A);
        mem_read(16'h0010, 1, q0, q1, q2);
        check("read_after_partial", q0, 8'h5A);

        // Illegal command
        en_seen = 1'b0;
        acc = 8'h00;
        cs_start();
        spi_byte(8'hFF, rx);
        spi_byte(8'hA5, rx); acc = acc | rx;
        spi_byte(8'hA5, rx); acc = acc | rx;
        spi_byte(8'hA5, rx); acc = acc | rx;
        cs_end();
        check("illegal_so_zero", acc, 8'h00);
        check("illegal_so_en_never", en_seen, 1'b0);
        peek(13'h0010, "illegal_no_write_0010", 8'h5A);
        peek(13'h0123, "illegal_no_write_0123", 8'hA5);

        // Reset in the middle of a READ
        wrsr(8'h41);
        cs_start();
        spi_byte(8'h03, rx);
        spi_byte(8'h01, rx);
        spi_byte(8'h23, rx);
        clks(6);
        check("pre_reset_msb", so, 1'b1);
        rst = 1'b1;
        #1;
        check("reset_mid_so", so, 1'b0);
        check("reset_mid_so_en", so_en, 1'b0);
        clks(3);
        rst = 1'b0;
        en_seen = 1'b0;
        spi_byte(8'h03, rx);
        check("after_reset_cs_low_so", rx, 8'h00);
        cs_end();
        check("after_reset_no_en", en_seen, 1'b0);
        rdsr(v);
        check("status_after_mid_reset", v, 8'h00);
        peek(13'h0123, "array_kept_0123", 8'hA5);
        peek(13'h1FFF, "array_kept_1fff", 8'h11);
        mem_read(16'h0020, 1, q0, q1, q2);
        check("read_after_reset", q0, 8'hCC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
